// File: rtl/exponent_multiplier_axi4_lite_master.sv
// AXI4-Lite master that runs one job on the exponent_multiplier slave: writes A, B,
// SELECT and START, polls DONE, then reads P back to the local req/done interface.
module exponent_multiplier_axi4_lite_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h7c80_0000,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          POLL_GAP      = 2,
  parameter int          MAX_POLLS     = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESET,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        i_req,
  input  logic [3:0]  i_A,
  input  logic [3:0]  i_B,
  input  logic        i_select,
  output logic        o_ready,
  output logic        o_done,
  output logic [29:0] o_P,
  output logic        o_error
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WRESP   = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_RD_DONE = 3'd4;
  localparam logic [2:0] ST_RD_P    = 3'd5;
  localparam logic [2:0] ST_GAP     = 3'd6;
  localparam logic [2:0] ST_FINISH  = 3'd7;

  localparam logic [31:0] OFF_P       = 32'h0000_0010;
  localparam logic [31:0] OFF_DONE    = 32'h0000_0014;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam logic [10:0] POLL_LIMIT  = 11'(MAX_POLLS);

  logic [2:0]  state_r;
  logic [3:0]  a_r;
  logic [3:0]  b_r;
  logic        sel_r;
  logic [1:0]  wr_idx_r;
  logic [10:0] poll_cnt_r;
  logic [15:0] wait_cnt_r;
  logic        unused_rdata;

  // Register writes go out in index order A, B, SELECT, START at consecutive word offsets.
  function automatic logic [31:0] wr_addr(input logic [1:0] idx);
    wr_addr = BASE_ADDR + {28'h0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] idx, input logic [3:0] a,
                                          input logic [3:0] b, input logic sel);
    case (idx)
      2'd0:    wr_data = {28'h0, a};
      2'd1:    wr_data = {28'h0, b};
      2'd2:    wr_data = {31'h0, sel};
      2'd3:    wr_data = 32'h0000_0001;
      default: wr_data = 32'h0000_0000;
    endcase
  endfunction

  assign M_AXI_WSTRB  = 4'hF;
  assign unused_rdata = ^M_AXI_RDATA[31:30];

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_r       <= ST_IDLE;
      a_r           <= 4'h0;
      b_r           <= 4'h0;
      sel_r         <= 1'b0;
      wr_idx_r      <= 2'd0;
      poll_cnt_r    <= 11'd0;
      wait_cnt_r    <= 16'd0;
      M_AXI_AWADDR  <= 32'h0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'h0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= 32'h0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      o_ready       <= 1'b1;
      o_done        <= 1'b0;
      o_P           <= 30'h0;
      o_error       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_req) begin
            a_r           <= i_A;
            b_r           <= i_B;
            sel_r         <= i_select;
            wr_idx_r      <= 2'd0;
            poll_cnt_r    <= 11'd0;
            o_error       <= 1'b0;
            o_ready       <= 1'b0;
            M_AXI_AWADDR  <= wr_addr(2'd0);
            M_AXI_WDATA   <= wr_data(2'd0, i_A, i_B, i_select);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state_r       <= ST_WR;
          end
        end
        ST_WR: begin
          // AW and W complete independently; move on once neither is still pending.
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state_r      <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              o_error <= 1'b1;
              o_done  <= 1'b1;
              state_r <= ST_FINISH;
            end else if (wr_idx_r == 2'd3) begin
              wait_cnt_r <= 16'd0;
              if (SETTLE_CYCLES == 0) begin
                M_AXI_ARADDR  <= BASE_ADDR + OFF_DONE;
                M_AXI_ARVALID <= 1'b1;
                state_r       <= ST_RD_DONE;
              end else begin
                state_r <= ST_SETTLE;
              end
            end else begin
              wr_idx_r      <= wr_idx_r + 2'd1;
              M_AXI_AWADDR  <= wr_addr(wr_idx_r + 2'd1);
              M_AXI_WDATA   <= wr_data(wr_idx_r + 2'd1, a_r, b_r, sel_r);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state_r       <= ST_WR;
            end
          end
        end
        ST_SETTLE: begin
          if (wait_cnt_r == SETTLE_LAST) begin
            M_AXI_ARADDR  <= BASE_ADDR + OFF_DONE;
            M_AXI_ARVALID <= 1'b1;
            state_r       <= ST_RD_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_RD_DONE: begin
          // ARVALID and RREADY are never high together: address phase first, then data.
          if (M_AXI_ARVALID) begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
            end
          end else if (M_AXI_RREADY && M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              o_error <= 1'b1;
              o_done  <= 1'b1;
              state_r <= ST_FINISH;
            end else if (M_AXI_RDATA[0]) begin
              M_AXI_ARADDR  <= BASE_ADDR + OFF_P;
              M_AXI_ARVALID <= 1'b1;
              state_r       <= ST_RD_P;
            end else if (poll_cnt_r + 11'd1 == POLL_LIMIT) begin
              poll_cnt_r <= poll_cnt_r + 11'd1;
              o_error    <= 1'b1;
              o_done     <= 1'b1;
              state_r    <= ST_FINISH;
            end else if (POLL_GAP == 0) begin
              poll_cnt_r    <= poll_cnt_r + 11'd1;
              M_AXI_ARVALID <= 1'b1;
            end else begin
              poll_cnt_r <= poll_cnt_r + 11'd1;
              wait_cnt_r <= 16'd0;
              state_r    <= ST_GAP;
            end
          end
        end
        ST_RD_P: begin
          if (M_AXI_ARVALID) begin
            if (M_AXI_ARREADY) begin
              M_AXI_ARVALID <= 1'b0;
              M_AXI_RREADY  <= 1'b1;
            end
          end else if (M_AXI_RREADY && M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              o_error <= 1'b1;
            end else begin
              o_P <= M_AXI_RDATA[29:0];
            end
            o_done  <= 1'b1;
            state_r <= ST_FINISH;
          end
        end
        ST_GAP: begin
          if (wait_cnt_r == GAP_LAST) begin
            M_AXI_ARVALID <= 1'b1;
            state_r       <= ST_RD_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_FINISH: begin
          o_ready <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          o_ready       <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exponent_multiplier_axi4_lite_master.sv
// Directed bench: a behavioural AXI4-Lite slave with configurable stalls answers the
// master, and a table of jobs is checked for bus traffic, result and error status.
module tb_exponent_multiplier_axi4_lite_master;
  localparam logic [31:0] BASE     = 32'h7c80_0000;
  localparam logic [31:0] ADDR_P   = BASE + 32'h10;
  localparam logic [31:0] ADDR_DN  = BASE + 32'h14;
  localparam int          POLL_GAP = 2;
  localparam int          NJOBS    = 9;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        sel;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    int          done_zeros;   // DONE=0 answers before DONE=1; -1 means never done
    logic [31:0] p;
    int          berr_idx;     // write index answered with SLVERR; -1 for none
    logic        rerr;         // SLVERR on the P read
    logic        hold;         // keep i_req high for the whole job
    int          exp_wr;
    int          exp_rd;
    logic        exp_err;
    logic [29:0] exp_p;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic i_req = 1'b0;
  logic [3:0] i_A = 4'd0, i_B = 4'd0;
  logic i_select = 1'b0;
  logic o_ready, o_done, o_error;
  logic [29:0] o_P;

  int checks = 0;
  int errors = 0;

  // slave configuration, written by the stimulus process
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_r_dly = 0, cfg_done_zeros = 0, cfg_berr_idx = -1;
  logic [31:0] cfg_p = 32'h0;
  logic cfg_rerr = 1'b0;
  int wr_base = 0, done_base = 0;

  // slave state and logs, written only by the slave process
  int wr_total = 0, done_total = 0, cyc = 0, proto_err = 0;
  logic [31:0] wr_log_addr [0:127];
  logic [31:0] wr_log_data [0:127];
  int done_cyc [0:255];
  logic aw_v_q, w_v_q, ar_v_q, b_ready_q, r_ready_q, pend_aw, pend_w, r_pend;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q, pend_addr, pend_data;
  int aw_wait, w_wait, r_wait;

  exponent_multiplier_axi4_lite_master #(
    .BASE_ADDR(BASE), .SETTLE_CYCLES(4), .POLL_GAP(POLL_GAP), .MAX_POLLS(8)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .i_req(i_req), .i_A(i_A), .i_B(i_B), .i_select(i_select),
    .o_ready(o_ready), .o_done(o_done), .o_P(o_P), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Slave runs on the falling edge: it first settles the handshakes of the rising
  // edge just passed (ready/valid as they stood then), then drives its next outputs.
  always @(negedge clk) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
      aw_v_q = 1'b0; w_v_q = 1'b0; ar_v_q = 1'b0; b_ready_q = 1'b0; r_ready_q = 1'b0;
      aw_addr_q = 32'h0; w_data_q = 32'h0; ar_addr_q = 32'h0;
      pend_aw = 1'b0; pend_w = 1'b0; r_pend = 1'b0;
      pend_addr = 32'h0; pend_data = 32'h0;
      aw_wait = 0; w_wait = 0; r_wait = 0;
    end else begin
      cyc++;
      if (aw_v_q && !awready && (!awvalid || awaddr != aw_addr_q)) proto_err++;
      if (w_v_q && !wready && (!wvalid || wdata != w_data_q)) proto_err++;
      if (ar_v_q && !arready && (!arvalid || araddr != ar_addr_q)) proto_err++;
      if (wvalid && wstrb != 4'hF) proto_err++;
      if (arvalid && rready) proto_err++;
      if (awready && aw_v_q) begin pend_aw = 1'b1; pend_addr = aw_addr_q; end
      if (wready && w_v_q) begin pend_w = 1'b1; pend_data = w_data_q; end
      if (bvalid && b_ready_q) bvalid = 1'b0;
      if (rvalid && r_ready_q) rvalid = 1'b0;
      if (arready && ar_v_q) begin
        r_pend = 1'b1; r_wait = 0; rresp = 2'b00;
        if (ar_addr_q == ADDR_DN) begin
          if (done_total < 256) done_cyc[done_total] = cyc;
          done_total++;
          rdata = (cfg_done_zeros >= 0 && (done_total - done_base) > cfg_done_zeros) ? 32'd1 : 32'd0;
        end else if (ar_addr_q == ADDR_P) begin
          rdata = cfg_p;
          if (cfg_rerr) rresp = 2'b10;
        end else begin
          rdata = 32'hDEAD_BEEF;
          proto_err++;
        end
      end
      if (pend_aw && pend_w && !bvalid) begin
        if (wr_total < 128) begin
          wr_log_addr[wr_total] = pend_addr;
          wr_log_data[wr_total] = pend_data;
        end
        bresp = ((wr_total - wr_base) == cfg_berr_idx) ? 2'b10 : 2'b00;
        wr_total++;
        bvalid = 1'b1; pend_aw = 1'b0; pend_w = 1'b0;
      end
      if (awvalid) begin
        if (aw_wait >= cfg_aw_dly) awready = 1'b1; else begin awready = 1'b0; aw_wait++; end
      end else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin
        if (w_wait >= cfg_w_dly) wready = 1'b1; else begin wready = 1'b0; w_wait++; end
      end else begin wready = 1'b0; w_wait = 0; end
      arready = arvalid;
      if (r_pend) begin
        if (r_wait >= cfg_r_dly) begin rvalid = 1'b1; r_pend = 1'b0; end else r_wait++;
      end
      aw_v_q = awvalid; aw_addr_q = awaddr; w_v_q = wvalid; w_data_q = wdata;
      ar_v_q = arvalid; ar_addr_q = araddr; b_ready_q = bready; r_ready_q = rready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_job(input job_t j, input string tag);
    cfg_aw_dly = j.aw_dly; cfg_w_dly = j.w_dly; cfg_r_dly = j.r_dly;
    cfg_done_zeros = j.done_zeros; cfg_p = j.p; cfg_berr_idx = j.berr_idx; cfg_rerr = j.rerr;
    wr_base = wr_total; done_base = done_total;
    i_A = j.a; i_B = j.b; i_select = j.sel; i_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!o_ready) break;
    end
    chk({tag, " accept"}, {31'h0, o_ready}, 32'd0);
    if (!j.hold) i_req = 1'b0;
  endtask

  task automatic finish_job(input job_t j, input string tag);
    logic seen;
    int nwr, nrd, min_gap;
    logic [31:0] exp_d;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; break; end
    end
    i_req = 1'b0;
    chk({tag, " done_seen"}, {31'h0, seen}, 32'd1);
    if (seen) begin
      chk({tag, " o_error"}, {31'h0, o_error}, {31'h0, j.exp_err});
      chk({tag, " o_P"}, {2'b00, o_P}, {2'b00, j.exp_p});
      @(negedge clk);
      chk({tag, " done_pulse_ready"}, {30'h0, o_done, o_ready}, 32'd1);
    end
    nwr = wr_total - wr_base;
    chk({tag, " n_writes"}, nwr, j.exp_wr);
    for (int i = 0; i < nwr && i < j.exp_wr; i++) begin
      case (i)
        0: exp_d = {28'h0, j.a};
        1: exp_d = {28'h0, j.b};
        2: exp_d = {31'h0, j.sel};
        default: exp_d = 32'd1;
      endcase
      chk($sformatf("%s wr%0d addr", tag, i), wr_log_addr[wr_base + i], BASE + 32'(4 * i));
      chk($sformatf("%s wr%0d data", tag, i), wr_log_data[wr_base + i], exp_d);
    end
    nrd = done_total - done_base;
    chk({tag, " n_done_reads"}, nrd, j.exp_rd);
    if (nrd >= 2) begin
      min_gap = 1000000;
      for (int i = done_base + 1; i < done_total; i++)
        if (done_cyc[i] - done_cyc[i - 1] < min_gap) min_gap = done_cyc[i] - done_cyc[i - 1];
      chk({tag, " poll_spacing_ok"}, {31'h0, min_gap >= POLL_GAP + 2}, 32'd1);
    end
  endtask

  job_t jobs [NJOBS];
  job_t rj;

  initial begin
    //            a     b     sel  awd wd rd zeros p              berr rerr  hold  wr rd err   p
    jobs[0] = '{4'd3, 4'd5, 1'b0, 0, 0, 0, 0, 32'd15,         -1, 1'b0, 1'b0, 4, 1, 1'b0, 30'd15};
    jobs[1] = '{4'd2, 4'd10,1'b1, 0, 0, 0, 2, 32'd1024,       -1, 1'b0, 1'b0, 4, 3, 1'b0, 30'd1024};
    jobs[2] = '{4'd7, 4'd9, 1'b0, 3, 0, 5, 1, 32'd63,         -1, 1'b0, 1'b0, 4, 2, 1'b0, 30'd63};
    jobs[3] = '{4'd4, 4'd3, 1'b1, 0, 3, 5, 0, 32'd64,         -1, 1'b0, 1'b1, 4, 1, 1'b0, 30'd64};
    jobs[4] = '{4'd1, 4'd1, 1'b0, 0, 0, 0, -1, 32'd999,       -1, 1'b0, 1'b0, 4, 8, 1'b1, 30'd64};
    jobs[5] = '{4'd6, 4'd6, 1'b1, 0, 0, 0, 0, 32'd36,          1, 1'b0, 1'b0, 2, 0, 1'b1, 30'd64};
    jobs[6] = '{4'd15,4'd15,1'b0, 0, 0, 0, 7, 32'd225,        -1, 1'b0, 1'b0, 4, 8, 1'b0, 30'd225};
    jobs[7] = '{4'd0, 4'd0, 1'b0, 2, 2, 1, 0, 32'hFFFF_FFFF,  -1, 1'b0, 1'b0, 4, 1, 1'b0, 30'h3FFF_FFFF};
    jobs[8] = '{4'd5, 4'd2, 1'b1, 0, 0, 0, 0, 32'd25,         -1, 1'b1, 1'b0, 4, 1, 1'b1, 30'h3FFF_FFFF};

    repeat (2) @(negedge clk);
    chk("rst valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst awaddr", awaddr, 32'd0);
    chk("rst araddr", araddr, 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk("rst status", {29'h0, o_ready, o_done, o_error}, 32'd4);
    chk("rst o_P", {2'b00, o_P}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < NJOBS; n++) begin
      start_job(jobs[n], $sformatf("job%0d", n));
      finish_job(jobs[n], $sformatf("job%0d", n));
      @(negedge clk);
    end

    // reset while a DONE read address is on the bus
    rj = '{4'd9, 4'd9, 1'b0, 0, 0, 0, -1, 32'd81, -1, 1'b0, 1'b0, 4, 0, 1'b0, 30'd81};
    start_job(rj, "rstjob");
    begin
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (arvalid) begin hit = 1'b1; break; end
      end
      chk("rstjob arvalid_seen", {31'h0, hit}, 32'd1);
      chk("rstjob araddr_done", araddr, ADDR_DN);
    end
    rst = 1'b1;
    #1;
    chk("async rst valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("async rst ready", {30'h0, o_ready, o_done}, 32'd2);
    chk("async rst o_P", {2'b00, o_P}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rj = '{4'd3, 4'd4, 1'b0, 0, 0, 0, 0, 32'd12, -1, 1'b0, 1'b0, 4, 1, 1'b0, 30'd12};
    start_job(rj, "postrst");
    finish_job(rj, "postrst");

    chk("protocol_violations", proto_err, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exponent_multiplier_axi4_lite_master.md
Name:
exponent_multiplier_axi4_lite_master

Overview:
AXI4-Lite master that runs one exponent/multiplier job on the memory-mapped exponent_multiplier slave: writes A, B and SELECT, writes START, polls DONE, then reads P. It sits between local control logic (simple req/done handshake) and the AXI4-Lite bus.

Parameters:
BASE_ADDR, 32'h7c800000, slave base; offsets are A +0x00, B +0x04, SELECT +0x08, START +0x0C, P +0x10, DONE +0x14
SETTLE_CYCLES, 4, idle cycles after the START write response before the first DONE poll
POLL_GAP, 2, idle cycles between consecutive DONE polls
MAX_POLLS, 1024, DONE reads allowed before the job is aborted with an error

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  asynchronous reset, active-high
M_AXI_AWADDR  out  32  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobe, constant 4'hF
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_ARADDR  out  32  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
i_req  in  1  job request; sampled only while o_ready=1
i_A  in  4  operand A
i_B  in  4  operand B
i_select  in  1  0 = multiply, 1 = exponent
o_ready  out  1  idle; a request is accepted when i_req=1 and o_ready=1
o_done  out  1  one-cycle pulse when the job ends
o_P  out  30  result; holds until the next job ends
o_error  out  1  valid with o_done: bad response or poll timeout

Behaviour:
- Reset values: all VALID/READY outputs 0, AWADDR/ARADDR/WDATA 0, o_ready 1, o_done 0, o_P 0, o_error 0, state IDLE. Reset mid-transaction drops every VALID immediately; no transaction is completed.
- Accepting a job (IDLE with i_req=1) latches i_A, i_B and i_select, drops o_ready, and sends the FSM to WR.
- WR: drives AWADDR/WDATA and raises AWVALID and WVALID in the same cycle. Each VALID is held until its own READY is seen; the two handshakes may complete in either order or together. AWADDR/WDATA stay stable while VALID is high.
- WR data per write, in fixed order: A = {28'b0, A}, B = {28'b0, B}, SELECT = {31'b0, sel}, START = 32'h1.
- WRESP: after both handshakes, BREADY=1 until BVALID. BRESP != 0 sets a sticky error and jumps to FINISH.
- After the START write: SETTLE waits SETTLE_CYCLES cycles, then RD_DONE.
- RD_DONE / RD_P: ARVALID is held until ARREADY, then RREADY=1 until RVALID. Only one outstanding read; ARVALID is never high together with RREADY.
- On a DONE read: RDATA[0]=1 goes to RD_P; otherwise the poll counter increments, POLL_GAP idle cycles follow, and the read repeats. Counter reaching MAX_POLLS with DONE still 0 sets the error and goes to FINISH.
- RD_P: o_P <= RDATA[29:0] on the R handshake. RRESP != 0 on any read sets the error.
- FINISH: o_done pulses for 1 cycle and o_error is valid that cycle. o_P is updated only on success and is otherwise unchanged. The next cycle is IDLE with o_ready=1.
- Minimum latency with zero-wait slave: 4 writes x 3 cycles + SETTLE + 2 reads x 3 cycles + 1.
- i_req while busy is ignored, not queued. Poll counter is 11 bits wide and cleared on every accept.

Test Plan:
- Multiply: A=3, B=5, sel=0, slave returns DONE=1 on the 1st poll and P=15 -> write sequence 0x7c800000=3, 0x7c800004=5, 0x7c800008=0, 0x7c80000C=1; o_done pulse with o_P=15 and o_error=0.
- Exponent: A=2, B=10, sel=1, DONE=0 twice then 1, P=1024 -> exactly 3 DONE reads spaced >= POLL_GAP apart; o_P=1024.
- Backpressure: slave delays AWREADY by 3 cycles and WREADY by 0 cycles (then swapped); RVALID delayed by 5 cycles -> VALIDs and addresses stable until handshake, result correct, no duplicate writes.
- Timeout: MAX_POLLS=8 and DONE stuck at 0 -> exactly 8 DONE reads, then o_done=1 with o_error=1 and o_P unchanged.
- Error response: BRESP=2'b10 on the B write -> no SELECT/START writes are issued; o_error=1; back to o_ready=1.
- Reset in RD_DONE with ARVALID=1 -> ARVALID=0 asynchronously, o_ready=1, and a new job completes normally after reset.
